// File: rtl/alu_ops_pkg.sv
// rtl/alu_ops_pkg.sv - shared funct codes, FSM states, shift directions and funct decode
package alu_ops_pkg;

    localparam logic [5:0] SLL = 6'b000000;
    localparam logic [5:0] SRL = 6'b000010;
    localparam logic [5:0] SRA = 6'b000011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        LEFT        = 2'd0,
        RIGHT_LOGIC = 2'd1,
        RIGHT_ARITH = 2'd2
    } dir_t;

    typedef struct packed {
        logic supported;
        dir_t dir;
    } op_dec_t;

    // Maps a funct code to a shift direction; SRA is only legal when sra_en is set
    function automatic op_dec_t decode_funct(input logic [5:0] funct, input logic sra_en);
        op_dec_t r;
        r.supported = 1'b0;
        r.dir       = LEFT;
        case (funct)
            SLL: begin
                r.supported = 1'b1;
                r.dir       = LEFT;
            end
            SRL: begin
                r.supported = 1'b1;
                r.dir       = RIGHT_LOGIC;
            end
            SRA: begin
                r.supported = sra_en;
                r.dir       = sra_en ? RIGHT_ARITH : LEFT;
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - request/response bundle between decode and the shift sequencer
interface shift_sequencer_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [5:0]       Signal;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dataOut;

    modport master (
        output start, Signal, dataA, dataB,
        input  busy, done, dataOut
    );

    modport slave (
        input  start, Signal, dataA, dataB,
        output busy, done, dataOut
    );
endinterface

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-bit shift of a vector in a chosen direction
module shift_step
    import alu_ops_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  dir_t             dir_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    // One bit per call; arithmetic right keeps replicating the current MSB
    always_comb begin
        data_o = data_i;
        case (dir_i)
            LEFT:        data_o = {data_i[WIDTH-2:0], 1'b0};
            RIGHT_LOGIC: data_o = {1'b0, data_i[WIDTH-1:1]};
            RIGHT_ARITH: data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
            default:     data_o = data_i;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - iterative one-bit-per-clock shifter; SHIFT_SRA_EN enables SRA
module shift_sequencer
    import alu_ops_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    shift_sequencer_if.slave bus
);

`ifdef SHIFT_SRA_EN
    localparam logic SRA_EN = 1'b1;
`else
    localparam logic SRA_EN = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dir_t             dir_q, dir_d;
    logic [WIDTH-1:0] dataOut_q, dataOut_d;

    op_dec_t          dec;
    logic [CNT_W-1:0] amt;
    logic [WIDTH-1:0] step_out;

    assign dec = decode_funct(bus.Signal, SRA_EN);

    // Clamp over the full dataB so huge amounts still mean "shift everything out"
    assign amt = (bus.dataB >= WIDTH'(WIDTH)) ? CNT_W'(WIDTH) : bus.dataB[CNT_W-1:0];

    shift_step #(.WIDTH(WIDTH)) u_step (
        .dir_i  (dir_q),
        .data_i (work_q),
        .data_o (step_out)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: a start is only honoured in IDLE, so busy/done cycles drop it
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; done is masked by reset so it can never appear with reset high
    always_comb begin
        bus.busy    = (state_q != IDLE);
        bus.done    = (state_q == DONE) && !reset;
        bus.dataOut = dataOut_q;
    end

    // Datapath next state: latch operands on accept, shift while counting, publish on exit
    always_comb begin
        work_d    = work_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        dataOut_d = dataOut_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dir_d = dec.dir;
                    if (dec.supported) begin
                        work_d = bus.dataA;
                        cnt_d  = amt;
                    end else begin
                        work_d = '0;
                        cnt_d  = '0;
                    end
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    work_d = step_out;
                    cnt_d  = cnt_q - CNT_W'(1);
                end else begin
                    dataOut_d = work_q;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            work_q    <= '0;
            cnt_q     <= '0;
            dir_q     <= LEFT;
            dataOut_q <= '0;
        end else begin
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            dataOut_q <= dataOut_d;
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed and random checks of shift_sequencer against a reference model
module tb_shift_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    shift_sequencer_if #(.WIDTH(32)) bus ();

    shift_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;

`ifdef SHIFT_SRA_EN
    localparam bit MODEL_SRA = 1'b1;
`else
    localparam bit MODEL_SRA = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_supported(input logic [5:0] f);
        return (f == 6'd0) || (f == 6'd2) || (MODEL_SRA && f == 6'd3);
    endfunction

    function automatic logic [31:0] model_result(input logic [5:0] f, input logic [31:0] a,
                                                  input logic [31:0] b);
        logic signed [31:0] s;
        s = a;
        if (f == 6'd0)      return (b >= 32) ? 32'd0 : (a << b);
        else if (f == 6'd2) return (b >= 32) ? 32'd0 : (a >> b);
        else if (MODEL_SRA && f == 6'd3)
            return (b >= 32) ? {32{a[31]}} : 32'(s >>> b[4:0]);
        else return 32'd0;
    endfunction

    function automatic int model_latency(input logic [5:0] f, input logic [31:0] b);
        int amt;
        amt = model_supported(f) ? ((b >= 32) ? 32 : int'(b)) : 0;
        return amt + 2;
    endfunction

    task automatic scramble_inputs();
        bus.Signal = 6'($urandom);
        bus.dataA  = $urandom;
        bus.dataB  = $urandom;
    endtask

    // Issues one request and follows it to completion; inject re-pulses start while busy
    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input bit inject);
        logic [31:0] exp;
        int lat, k, extra;
        bit got;
        exp = model_result(f, a, b);
        lat = model_latency(f, b);
        @(negedge clk);
        bus.start = 1'b1; bus.Signal = f; bus.dataA = a; bus.dataB = b;
        k = 0; got = 1'b0;
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            if (bus.done === 1'b1) begin
                got = 1'b1;
            end else begin
                check({tag, "_busy"}, 32'(bus.busy), 32'd1);
                bus.start = inject && (k == 2);
                scramble_inputs();
            end
        end
        check({tag, "_lat"}, k, lat);
        check({tag, "_data"}, bus.dataOut, exp);
        check({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
        // start coinciding with done must be dropped
        bus.start = 1'b1;
        scramble_inputs();
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_done_clr"}, 32'(bus.done), 32'd0);
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
        check({tag, "_hold"}, bus.dataOut, exp);
        if (inject) begin
            extra = 0;
            repeat (12) begin
                @(negedge clk);
                if (bus.done === 1'b1) extra++;
            end
            check({tag, "_extra_done"}, extra, 0);
        end
    endtask

    initial begin
        int k, extra;
        logic [5:0]  f;
        logic [31:0] a, b;

        reset = 1'b1;
        bus.start = 1'b0; bus.Signal = '0; bus.dataA = '0; bus.dataB = '0;
        repeat (2) @(negedge clk);
        check("rst_dout", bus.dataOut, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_dout", bus.dataOut, 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_done", 32'(bus.done), 32'd0);

        run_op("srl_basic", 6'b000010, 32'hF000_0000, 32'd4, 1'b0);
        check("srl_basic_const", bus.dataOut, 32'h0F00_0000);
        run_op("sll_zero", 6'b000000, 32'h0000_0001, 32'd0, 1'b0);
        run_op("srl_big", 6'b000010, 32'hDEAD_BEEF, 32'h0000_0100, 1'b0);
        run_op("sll_32", 6'b000000, 32'hFFFF_FFFF, 32'd32, 1'b0);
        run_op("sll_31", 6'b000000, 32'h0000_0003, 32'd31, 1'b0);
        run_op("busy_rej", 6'b000010, 32'h8765_4321, 32'd8, 1'b1);

        // Reset in the middle of a 20-bit shift
        @(negedge clk);
        bus.start = 1'b1; bus.Signal = 6'b000010; bus.dataA = 32'hFFFF_0000; bus.dataB = 32'd20;
        for (k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_dout", bus.dataOut, 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        extra = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done === 1'b1) extra++;
        end
        check("midrst_no_done", extra, 0);
        run_op("after_rst", 6'b000010, 32'hFFFF_0000, 32'd20, 1'b0);

        run_op("sra_or_unsup", 6'b000011, 32'h8000_0000, 32'd4, 1'b0);
        run_op("sra_big", 6'b000011, 32'h8000_0001, 32'hFFFF_FFFF, 1'b0);
        run_op("unsup", 6'b101010, 32'h1234_5678, 32'd3, 1'b0);

        for (int i = 0; i < 24; i++) begin
            case ($urandom % 4)
                0: f = 6'b000000;
                1: f = 6'b000010;
                2: f = 6'b000011;
                default: f = 6'($urandom);
            endcase
            a = $urandom;
            case ($urandom % 3)
                0: b = $urandom;
                default: b = $urandom % 34;
            endcase
            run_op("rand", f, a, b, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
